// File: rtl/blink_pkg.sv
// Shared types and default timing constants for the blink monitor.
// Pure declarations: no latency, no flow control.
package blink_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_ON   = 2'd1,
    MEAS_OFF  = 2'd2
  } state_t;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_OFF_CYCLES = 4;
  localparam int DEF_TOL        = 0;

  // Larger minus smaller, so the distance never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/led_edge_det.sv
// Registers the blink line once and flags rising/falling samples.
// Rise/fall are combinational against the one-cycle-old sample; no backpressure.
module led_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_led,
  output logic o_rise,
  output logic o_fall
);

  logic r_led_d;

  // Reset high so a line already high at release is not seen as a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led_d <= 1'b1;
    end else begin
      r_led_d <= i_led;
    end
  end

  assign o_rise = i_led & ~r_led_d;
  assign o_fall = ~i_led & r_led_d;

endmodule

// File: rtl/blink_monitor.sv
// Measures high/low durations of a blink line and judges each period against tolerance.
// Results appear one cycle after the closing rise; no backpressure, len_valid is a pulse.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int TOL        = DEF_TOL
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             led_in,
  output logic [CNT_W-1:0] on_len,
  output logic [CNT_W-1:0] off_len,
  output logic             len_valid,
  output logic             blink_ok,
  output logic             err_pulse,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0]      ON_U    = ON_CYCLES;
  localparam logic [31:0]      OFF_U   = OFF_CYCLES;
  localparam logic [31:0]      TOL_U   = TOL;

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [CNT_W-1:0] r_on_len,    w_on_nxt;
  logic [CNT_W-1:0] r_off_len,   w_off_nxt;
  logic             r_len_valid, w_len_valid_nxt;
  logic             r_blink_ok,  w_blink_ok_nxt;
  logic             r_err,       w_err_nxt;
  logic [1:0]       r_good,      w_good_nxt;

  logic w_rise;
  logic w_fall;
  logic w_in_tol;

  led_edge_det u_edge (
    .i_clk   (clk),
    .i_rst_n (clear_n),
    .i_led   (led_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // The closing low run is still in r_cnt when the rise arrives.
  assign w_in_tol = (abs_diff(32'(r_on_len), ON_U) <= TOL_U) &&
                    (abs_diff(32'(r_cnt), OFF_U) <= TOL_U);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_on_nxt        = r_on_len;
    w_off_nxt       = r_off_len;
    w_len_valid_nxt = 1'b0;
    w_blink_ok_nxt  = r_blink_ok;
    w_err_nxt       = 1'b0;
    w_good_nxt      = r_good;

    case (r_state)
      WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = MEAS_ON;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      MEAS_ON, MEAS_OFF: begin
        if (r_cnt == CNT_MAX) begin
          // Saturated run: abandon the period rather than wrap the counter.
          w_state_nxt    = WAIT_RISE;
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_blink_ok_nxt = 1'b0;
          w_good_nxt     = 2'd0;
        end else if (r_state == MEAS_ON) begin
          if (w_fall) begin
            w_on_nxt    = r_cnt;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = MEAS_OFF;
          end else if (led_in) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          if (w_rise) begin
            w_off_nxt       = r_cnt;
            w_cnt_nxt       = CNT_ONE;
            w_state_nxt     = MEAS_ON;
            w_len_valid_nxt = 1'b1;
            if (w_in_tol) begin
              w_blink_ok_nxt = 1'b1;
              w_good_nxt     = (r_good == 2'd2) ? 2'd2 : r_good + 2'd1;
            end else begin
              w_blink_ok_nxt = 1'b0;
              w_err_nxt      = 1'b1;
              w_good_nxt     = 2'd0;
            end
          end else if (!led_in) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = WAIT_RISE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= WAIT_RISE;
      r_cnt       <= '0;
      r_on_len    <= '0;
      r_off_len   <= '0;
      r_len_valid <= 1'b0;
      r_blink_ok  <= 1'b0;
      r_err       <= 1'b0;
      r_good      <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_on_len    <= w_on_nxt;
      r_off_len   <= w_off_nxt;
      r_len_valid <= w_len_valid_nxt;
      r_blink_ok  <= w_blink_ok_nxt;
      r_err       <= w_err_nxt;
      r_good      <= w_good_nxt;
    end
  end

  assign on_len    = r_on_len;
  assign off_len   = r_off_len;
  assign len_valid = r_len_valid;
  assign blink_ok  = r_blink_ok;
  assign err_pulse = r_err;
  assign locked    = (r_good == 2'd2);

endmodule

// File: tb/tb_blink_monitor.sv
// Drives one blink line into two monitors (wide/strict and narrow/tolerant) and
// compares every cycle against a run-length reference model.
module tb_blink_monitor;

  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic led_in = 1'b0;

  logic [15:0] a_on_len, a_off_len;
  logic        a_len_valid, a_blink_ok, a_err_pulse, a_locked;
  logic [3:0]  b_on_len, b_off_len;
  logic        b_len_valid, b_blink_ok, b_err_pulse, b_locked;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int prev;
    int armed;
    int run;
    int on_len;
    int off_len;
    int len_valid;
    int err;
    int ok;
    int good;
  } mdl_t;

  mdl_t ma, mb;

  blink_monitor #(.CNT_W(16), .ON_CYCLES(4), .OFF_CYCLES(4), .TOL(0)) dut_a (
    .clk(clk), .clear_n(clear_n), .led_in(led_in),
    .on_len(a_on_len), .off_len(a_off_len), .len_valid(a_len_valid),
    .blink_ok(a_blink_ok), .err_pulse(a_err_pulse), .locked(a_locked)
  );

  blink_monitor #(.CNT_W(4), .ON_CYCLES(4), .OFF_CYCLES(4), .TOL(1)) dut_b (
    .clk(clk), .clear_n(clear_n), .led_in(led_in),
    .on_len(b_on_len), .off_len(b_off_len), .len_valid(b_len_valid),
    .blink_ok(b_blink_ok), .err_pulse(b_err_pulse), .locked(b_locked)
  );

  always #5 clk = ~clk;

  function automatic int absd(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{prev: 1, default: 0};
    return m;
  endfunction

  // Level runs: a rise opens measurement, a fall closes the high run,
  // the next rise closes the low run and completes a period.
  function automatic mdl_t mdl_step(input mdl_t m_in, input int s, input int maxc,
                                    input int onc, input int offc, input int tol);
    mdl_t m;
    m = m_in;
    m.len_valid = 0;
    m.err = 0;
    if (m.armed != 0 && m.run == maxc) begin
      m.armed = 0;
      m.err = 1;
      m.ok = 0;
      m.good = 0;
    end else if (m.armed != 0) begin
      if (s != m.prev) begin
        if (s == 0) begin
          m.on_len = m.run;
        end else begin
          m.off_len = m.run;
          m.len_valid = 1;
          if (absd(m.on_len, onc) <= tol && absd(m.off_len, offc) <= tol) begin
            m.ok = 1;
            m.good = (m.good < 2) ? m.good + 1 : 2;
          end else begin
            m.ok = 0;
            m.err = 1;
            m.good = 0;
          end
        end
        m.run = 1;
      end else begin
        m.run = m.run + 1;
      end
    end else if (s == 1 && m.prev == 0) begin
      m.armed = 1;
      m.run = 1;
    end
    m.prev = s;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("a_len_valid", 32'(a_len_valid), ma.len_valid);
    chk("a_err_pulse", 32'(a_err_pulse), ma.err);
    chk("a_blink_ok",  32'(a_blink_ok),  ma.ok);
    chk("a_locked",    32'(a_locked),    (ma.good == 2) ? 1 : 0);
    chk("a_on_len",    32'(a_on_len),    ma.on_len);
    chk("a_off_len",   32'(a_off_len),   ma.off_len);
    chk("b_len_valid", 32'(b_len_valid), mb.len_valid);
    chk("b_err_pulse", 32'(b_err_pulse), mb.err);
    chk("b_blink_ok",  32'(b_blink_ok),  mb.ok);
    chk("b_locked",    32'(b_locked),    (mb.good == 2) ? 1 : 0);
    chk("b_on_len",    32'(b_on_len),    mb.on_len);
    chk("b_off_len",   32'(b_off_len),   mb.off_len);
  endtask

  // Entered and left at a falling edge.
  task automatic cyc(input logic v);
    led_in = v;
    @(posedge clk);
    #1;
    if (!clear_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, int'(v), MAX_A, 4, 4, 0);
      mb = mdl_step(mb, int'(v), MAX_B, 4, 4, 1);
    end
    check_all();
    @(negedge clk);
  endtask

  task automatic period(input int hi, input int lo);
    repeat (hi) cyc(1'b1);
    repeat (lo) cyc(1'b0);
  endtask

  task automatic do_reset(input int n);
    clear_n = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_all();
    repeat (n) cyc(led_in);
    clear_n = 1'b1;
  endtask

  initial begin
    int hi, lo;
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge clk);
    do_reset(2);

    // Nominal 4/4 blinking reaches lock on the second period.
    repeat (3) cyc(1'b0);
    repeat (3) period(4, 4);
    cyc(1'b1);
    chk("nominal_locked", 32'(a_locked), 1);
    chk("nominal_on_len", 32'(a_on_len), 4);

    // Long high phase breaks lock at zero tolerance.
    repeat (5) cyc(1'b1);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    chk("long_on_err", 32'(a_err_pulse), 1);
    chk("long_on_len", 32'(a_on_len), 6);
    chk("long_on_unlocked", 32'(a_locked), 0);

    // 5/3 is accepted by the tolerant monitor only.
    repeat (4) cyc(1'b1);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk("tol1_ok", 32'(b_blink_ok), 1);
    chk("tol1_no_err", 32'(b_err_pulse), 0);
    chk("tol0_err", 32'(a_err_pulse), 1);

    // Line high across reset release: no rise until it has dropped.
    led_in = 1'b1;
    do_reset(2);
    repeat (3) cyc(1'b1);
    repeat (4) cyc(1'b0);
    period(4, 4);
    cyc(1'b1);
    chk("high_release_valid", 32'(a_len_valid), 1);

    // Stuck low: narrow monitor times out, wide one keeps counting.
    repeat (2) cyc(1'b1);
    repeat (20) cyc(1'b0);
    cyc(1'b1);
    chk("stuck_wide_off_len", 32'(a_off_len), 20);

    // Reset in the middle of a low phase.
    repeat (3) cyc(1'b1);
    repeat (2) cyc(1'b0);
    do_reset(2);
    chk("midreset_on_len", 32'(a_on_len), 0);
    period(1, 4);
    period(4, 4);
    cyc(1'b1);
    chk("after_reset_off_len", 32'(a_off_len), 4);

    // Random periods, mostly near nominal, with glitches, long runs and resets.
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(1, 2)));
      if ($urandom_range(0, 3) != 0) begin
        hi = int'($urandom_range(3, 5));
        lo = int'($urandom_range(3, 5));
      end else begin
        hi = int'($urandom_range(1, 18));
        lo = int'($urandom_range(1, 18));
      end
      period(hi, lo);
    end
    cyc(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
